// File: rtl/ysyx_23060059_clint.sv
// Core-local interruptor: AXI4 responder holding mtime (RO) and mtimecmp (RW), raising timer_irq_o.
// Define CLINT_PRESCALE_EN to advance mtime once every DIV clocks instead of every clock.
module ysyx_23060059_clint #(
    parameter logic [31:0] BASE = 32'h0200_0000,
    parameter int unsigned DIV  = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] araddr,
    input  logic [3:0]  arid,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready_o,
    output logic [63:0] rdata_o,
    output logic [1:0]  rresp_o,
    output logic [3:0]  rid_o,
    output logic        rlast_o,
    output logic        rvalid_o,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awid,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready_o,
    input  logic [63:0] wdata,
    input  logic [7:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready_o,
    output logic [1:0]  bresp_o,
    output logic        bvalid_o,
    input  logic        bready,
    output logic        timer_irq_o
);

    typedef enum logic       {R_IDLE, R_DATA} rstate_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic [1:0] {SEL_MTIME, SEL_CMP, SEL_ERR} sel_e;

    function automatic sel_e decode(input logic [31:0] addr);
        logic [31:0] off;
        off = (addr - BASE) & ~32'h7;
        if (off == 32'h0)      return SEL_MTIME;
        else if (off == 32'h8) return SEL_CMP;
        else                   return SEL_ERR;
    endfunction

    // FIXED keeps the address; INCR, WRAP and reserved encodings all step by one 64-bit beat.
    function automatic logic [31:0] step(input logic [31:0] addr, input logic [1:0] burst);
        return (burst == 2'b00) ? addr : addr + 32'd8;
    endfunction

    logic        tick;
    logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
    logic        irq_q;
    logic        unused_ok;

    rstate_e     r_state_q, r_state_d;
    logic [31:0] raddr_q, raddr_d, rd_addr;
    logic [7:0]  rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [1:0]  rburst_q, rburst_d;
    logic [3:0]  rid_q, rid_d;
    logic        arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [63:0] rdata_q, rdata_d, rd_word;
    logic [1:0]  rresp_q, rresp_d, rd_resp;

    wstate_e     w_state_q, w_state_d;
    logic [31:0] waddr_q, waddr_d;
    logic [7:0]  wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [1:0]  wburst_q, wburst_d, bresp_q, bresp_d;
    logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic        werr_q, werr_d, err_beat, cnt_last;

    assign unused_ok = ^{arsize, awsize, awid};

`ifdef CLINT_PRESCALE_EN
    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    logic [PW-1:0] presc_q, presc_d;

    always_comb begin
        tick    = (presc_q == PW'(DIV - 1));
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) presc_q <= '0;
        else        presc_q <= presc_d;
    end
`else
    logic [31:0] unused_div;
    assign unused_div = 32'(DIV);
    assign tick       = 1'b1;
`endif

    assign mtime_d = mtime_q + {63'd0, tick};

    always_comb begin
        rd_addr = (r_state_q == R_IDLE) ? araddr : step(raddr_q, rburst_q);
        rd_word = '0;
        rd_resp = 2'b00;
        case (decode(rd_addr))
            SEL_MTIME: rd_word = mtime_q;
            SEL_CMP:   rd_word = mtimecmp_q;
            default:   rd_resp = 2'b10;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rcnt_d    = rcnt_q;
        rburst_d  = rburst_q;
        rid_d     = rid_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (arvalid && arready_q) begin
                    raddr_d   = araddr;
                    rlen_d    = arlen;
                    rburst_d  = arburst;
                    rid_d     = arid;
                    rcnt_d    = '0;
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_word;
                    rresp_d   = rd_resp;
                    rlast_d   = (arlen == 8'd0);
                    arready_d = 1'b0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rready) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        rcnt_d  = rcnt_q + 8'd1;
                        raddr_d = rd_addr;
                        rdata_d = rd_word;
                        rresp_d = rd_resp;
                        rlast_d = (rcnt_d == rlen_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d  = w_state_q;
        waddr_d    = waddr_q;
        wlen_d     = wlen_q;
        wcnt_d     = wcnt_q;
        wburst_d   = wburst_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        werr_d     = werr_q;
        mtimecmp_d = mtimecmp_q;
        err_beat   = 1'b0;
        cnt_last   = (wcnt_q == wlen_q);
        case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (awvalid && awready_q) begin
                    waddr_d   = awaddr;
                    wlen_d    = awlen;
                    wburst_d  = awburst;
                    wcnt_d    = '0;
                    werr_d    = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid && wready_q) begin
                    if (decode(waddr_q) == SEL_CMP) begin
                        for (int unsigned i = 0; i < 8; i++) begin
                            if (wstrb[i]) mtimecmp_d[8*i +: 8] = wdata[8*i +: 8];
                        end
                    end else begin
                        err_beat = 1'b1;
                    end
                    // Either end condition closes the burst; disagreement between them is an error.
                    if (wlast || cnt_last) begin
                        err_beat  = err_beat | (wlast != cnt_last);
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = (werr_q || err_beat) ? 2'b10 : 2'b00;
                        w_state_d = W_RESP;
                    end else begin
                        wcnt_d  = wcnt_q + 8'd1;
                        waddr_d = step(waddr_q, wburst_q);
                    end
                    werr_d = werr_q | err_beat;
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d  = 1'b0;
                    bresp_d   = 2'b00;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            irq_q      <= 1'b0;
            r_state_q  <= R_IDLE;
            raddr_q    <= '0;
            rlen_q     <= '0;
            rcnt_q     <= '0;
            rburst_q   <= '0;
            rid_q      <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            w_state_q  <= W_IDLE;
            waddr_q    <= '0;
            wlen_q     <= '0;
            wcnt_q     <= '0;
            wburst_q   <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            werr_q     <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            irq_q      <= (mtime_q >= mtimecmp_q);
            r_state_q  <= r_state_d;
            raddr_q    <= raddr_d;
            rlen_q     <= rlen_d;
            rcnt_q     <= rcnt_d;
            rburst_q   <= rburst_d;
            rid_q      <= rid_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            w_state_q  <= w_state_d;
            waddr_q    <= waddr_d;
            wlen_q     <= wlen_d;
            wcnt_q     <= wcnt_d;
            wburst_q   <= wburst_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            werr_q     <= werr_d;
        end
    end

    assign arready_o   = arready_q;
    assign rdata_o     = rdata_q;
    assign rresp_o     = rresp_q;
    assign rid_o       = rid_q;
    assign rlast_o     = rlast_q;
    assign rvalid_o    = rvalid_q;
    assign awready_o   = awready_q;
    assign wready_o    = wready_q;
    assign bresp_o     = bresp_q;
    assign bvalid_o    = bvalid_q;
    assign timer_irq_o = irq_q;

endmodule

// File: tb/tb_ysyx_23060059_clint.sv
// Directed bench for ysyx_23060059_clint: one task per scenario, inline checks, one summary line.
module tb_ysyx_23060059_clint;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk, reset;
    logic [31:0] araddr, awaddr;
    logic [3:0]  arid, awid, rid_o;
    logic [7:0]  arlen, awlen, wstrb;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp_o, bresp_o;
    logic        arvalid, arready_o, rlast_o, rvalid_o, rready;
    logic        awvalid, awready_o, wlast, wvalid, wready_o, bvalid_o, bready, timer_irq_o;
    logic [63:0] rdata_o, wdata;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc;

    ysyx_23060059_clint #(.BASE(BASE), .DIV(4)) dut (
        .clock(clk), .reset(reset),
        .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready_o(arready_o),
        .rdata_o(rdata_o), .rresp_o(rresp_o), .rid_o(rid_o), .rlast_o(rlast_o),
        .rvalid_o(rvalid_o), .rready(rready),
        .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready_o(awready_o),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready_o(wready_o),
        .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready(bready),
        .timer_irq_o(timer_irq_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cyc = index of the current cycle; cycle 0 is the one in which reset is released.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic clear_inputs();
        araddr = '0; arid = '0; arlen = '0; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; awid = '0; awlen = '0; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    endtask

    // Leaves the bench #1 into cycle 0.
    task automatic apply_reset();
        reset = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Single-beat AR; returns one cycle after the handshake.
    task automatic do_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len, input logic [1:0] burst);
        araddr = a; arid = id; arlen = len; arburst = burst; arvalid = 1'b1;
        next_cycle();
        arvalid = 1'b0;
    endtask

    // Single-beat write; 3 cycles from AW to returning with the B handshake done.
    task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                            output logic [1:0] resp, output bit got_b);
        awaddr = a; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
        next_cycle();
        awvalid = 1'b0;
        wdata = d; wstrb = s; wlast = 1'b1; wvalid = 1'b1;
        next_cycle();
        wvalid = 1'b0; wlast = 1'b0;
        got_b = 1'b0;
        resp  = 2'b11;
        for (int i = 0; i < 8 && !got_b; i++) begin
            if (bvalid_o) begin
                got_b = 1'b1;
                resp  = bresp_o;
            end else begin
                next_cycle();
            end
        end
        bready = 1'b1;
        next_cycle();
        bready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        tests_run++; if ({arready_o, awready_o, wready_o, rvalid_o, bvalid_o, timer_irq_o, rlast_o} !== 7'b0) begin tests_failed++; $display("FAIL reset_ctrl: got %b want 0000000", {arready_o, awready_o, wready_o, rvalid_o, bvalid_o, timer_irq_o, rlast_o}); end
        tests_run++; if ({rdata_o, rresp_o, rid_o, bresp_o} !== 72'd0) begin tests_failed++; $display("FAIL reset_data: got %h want 0", {rdata_o, rresp_o, rid_o, bresp_o}); end
        reset = 1'b1;
        #1;
        tests_run++; if (arready_o !== 1'b0) begin tests_failed++; $display("FAIL reset_arready_c0: got %b want 0", arready_o); end
        next_cycle();
        tests_run++; if ({arready_o, awready_o, wready_o} !== 3'b110) begin tests_failed++; $display("FAIL reset_ready_c1: got %b want 110", {arready_o, awready_o, wready_o}); end
    endtask

    task automatic test_mtime_read();
        apply_reset();
        repeat (10) next_cycle();
        do_ar(BASE, 4'h3, 8'd0, 2'b01);
        tests_run++; if (rvalid_o !== 1'b1) begin tests_failed++; $display("FAIL t1_rvalid: got %b want 1", rvalid_o); end
        tests_run++; if (rdata_o !== 64'd10) begin tests_failed++; $display("FAIL t1_rdata: got %h want %h", rdata_o, 64'd10); end
        tests_run++; if ({rresp_o, rlast_o, rid_o} !== {2'b00, 1'b1, 4'h3}) begin tests_failed++; $display("FAIL t1_resp_last_id: got %b want 0013", {rresp_o, rlast_o, rid_o}); end
        tests_run++; if (arready_o !== 1'b0) begin tests_failed++; $display("FAIL t1_arready_busy: got %b want 0", arready_o); end
        rready = 1'b1;
        next_cycle();
        rready = 1'b0;
        tests_run++; if ({rvalid_o, arready_o} !== 2'b01) begin tests_failed++; $display("FAIL t1_done: got %b want 01", {rvalid_o, arready_o}); end
    endtask

    task automatic test_timer_irq();
        logic [1:0] resp;
        bit got_b, early;
        apply_reset();
        next_cycle();
        do_write(BASE + 32'h8, 64'd100, 8'hFF, resp, got_b);
        tests_run++; if ({got_b, resp} !== 3'b100) begin tests_failed++; $display("FAIL t2_bresp: got %b want 100", {got_b, resp}); end
        early = 1'b0;
        while (cyc < 100) begin
            if (timer_irq_o !== 1'b0) early = 1'b1;
            next_cycle();
        end
        tests_run++; if (early !== 1'b0) begin tests_failed++; $display("FAIL t2_irq_early: got %b want 0", early); end
        tests_run++; if (timer_irq_o !== 1'b0) begin tests_failed++; $display("FAIL t2_irq_c100: got %b want 0", timer_irq_o); end
        next_cycle();
        tests_run++; if (timer_irq_o !== 1'b1) begin tests_failed++; $display("FAIL t2_irq_c101: got %b want 1", timer_irq_o); end
        repeat (5) next_cycle();
        tests_run++; if (timer_irq_o !== 1'b1) begin tests_failed++; $display("FAIL t2_irq_hold: got %b want 1", timer_irq_o); end
    endtask

    task automatic test_wstrb();
        logic [1:0] resp;
        bit got_b;
        apply_reset();
        next_cycle();
        do_write(BASE + 32'h8, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, resp, got_b);
        tests_run++; if ({got_b, resp} !== 3'b100) begin tests_failed++; $display("FAIL t3_bresp: got %b want 100", {got_b, resp}); end
        rready = 1'b1;
        do_ar(BASE + 32'h8, 4'h1, 8'd0, 2'b01);
        tests_run++; if (rdata_o !== 64'hFFFF_FFFF_CCCC_DDDD) begin tests_failed++; $display("FAIL t3_rdata: got %h want ffffffffccccdddd", rdata_o); end
        next_cycle();
        rready = 1'b0;
    endtask

    task automatic test_burst_stall();
        logic [1:0] resp;
        bit got_b;
        apply_reset();
        next_cycle();
        do_write(BASE + 32'h8, 64'h1234_5678_9ABC_DEF0, 8'hFF, resp, got_b);
        rready = 1'b0;
        do_ar(BASE, 4'h5, 8'd1, 2'b01);
        tests_run++; if ({rvalid_o, rlast_o, rdata_o} !== {2'b10, 64'd4}) begin tests_failed++; $display("FAIL t4_beat0: got %b %b %h want 1 0 4", rvalid_o, rlast_o, rdata_o); end
        next_cycle();
        tests_run++; if ({rvalid_o, rlast_o, rdata_o} !== {2'b10, 64'd4}) begin tests_failed++; $display("FAIL t4_beat0_hold: got %b %b %h want 1 0 4", rvalid_o, rlast_o, rdata_o); end
        rready = 1'b1;
        next_cycle();
        rready = 1'b0;
        tests_run++; if ({rvalid_o, rlast_o, rdata_o, rid_o} !== {2'b11, 64'h1234_5678_9ABC_DEF0, 4'h5}) begin tests_failed++; $display("FAIL t4_beat1: got %b %b %h %h want 1 1 123456789abcdef0 5", rvalid_o, rlast_o, rdata_o, rid_o); end
        next_cycle();
        tests_run++; if ({rvalid_o, rlast_o, rdata_o} !== {2'b11, 64'h1234_5678_9ABC_DEF0}) begin tests_failed++; $display("FAIL t4_beat1_hold: got %b %b %h want 1 1 123456789abcdef0", rvalid_o, rlast_o, rdata_o); end
        rready = 1'b1;
        next_cycle();
        rready = 1'b0;
        tests_run++; if ({rvalid_o, arready_o} !== 2'b01) begin tests_failed++; $display("FAIL t4_done: got %b want 01", {rvalid_o, arready_o}); end
    endtask

    task automatic test_errors();
        logic [1:0] resp;
        bit got_b;
        apply_reset();
        next_cycle();
        rready = 1'b1;
        do_ar(BASE + 32'h10, 4'h2, 8'd0, 2'b01);
        tests_run++; if ({rvalid_o, rresp_o, rlast_o, rdata_o} !== {1'b1, 2'b10, 1'b1, 64'd0}) begin tests_failed++; $display("FAIL t5_rd_err: got %b %b %b %h want 1 10 1 0", rvalid_o, rresp_o, rlast_o, rdata_o); end
        next_cycle();
        do_write(BASE, 64'h5555_5555_5555_5555, 8'hFF, resp, got_b);
        tests_run++; if ({got_b, resp} !== 3'b110) begin tests_failed++; $display("FAIL t5_wr_err: got %b want 110", {got_b, resp}); end
        do_ar(BASE + 32'h4, 4'h2, 8'd0, 2'b01);
        tests_run++; if ({rresp_o, rdata_o} !== {2'b00, 64'd6}) begin tests_failed++; $display("FAIL t5_mtime_kept: got %b %h want 00 6", rresp_o, rdata_o); end
        next_cycle();
        do_ar(BASE + 32'hC, 4'h2, 8'd0, 2'b01);
        tests_run++; if ({rresp_o, rdata_o} !== {2'b00, 64'hFFFF_FFFF_FFFF_FFFF}) begin tests_failed++; $display("FAIL t5_unaligned_cmp: got %b %h want 00 ffffffffffffffff", rresp_o, rdata_o); end
        next_cycle();
        rready = 1'b0;
    endtask

    task automatic test_write_burst();
        apply_reset();
        next_cycle();
        awaddr = BASE; awlen = 8'd1; awburst = 2'b01; awvalid = 1'b1;
        next_cycle();
        awvalid = 1'b0;
        tests_run++; if ({wready_o, awready_o} !== 2'b10) begin tests_failed++; $display("FAIL t8_wready: got %b want 10", {wready_o, awready_o}); end
        wdata = 64'h1111_1111_1111_1111; wstrb = 8'hFF; wlast = 1'b0; wvalid = 1'b1;
        next_cycle();
        wdata = 64'h0BAD_F00D_0000_0042; wlast = 1'b1;
        next_cycle();
        wvalid = 1'b0; wlast = 1'b0;
        tests_run++; if ({bvalid_o, bresp_o, wready_o} !== 4'b1100) begin tests_failed++; $display("FAIL t8_sticky_err: got %b want 1100", {bvalid_o, bresp_o, wready_o}); end
        bready = 1'b1;
        next_cycle();
        bready = 1'b0;
        rready = 1'b1;
        do_ar(BASE + 32'h8, 4'h0, 8'd0, 2'b01);
        tests_run++; if (rdata_o !== 64'h0BAD_F00D_0000_0042) begin tests_failed++; $display("FAIL t8_cmp_beat1: got %h want 0badf00d00000042", rdata_o); end
        next_cycle();
        rready = 1'b0;
        awaddr = BASE + 32'h8; awlen = 8'd1; awvalid = 1'b1;
        next_cycle();
        awvalid = 1'b0;
        wdata = 64'd7; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
        next_cycle();
        wvalid = 1'b0; wlast = 1'b0;
        tests_run++; if ({bvalid_o, bresp_o} !== 3'b110) begin tests_failed++; $display("FAIL t8_wlast_early: got %b want 110", {bvalid_o, bresp_o}); end
        bready = 1'b1;
        next_cycle();
        bready = 1'b0;
    endtask

    task automatic test_reset_midburst();
        bit extra;
        apply_reset();
        next_cycle();
        rready = 1'b0;
        do_ar(BASE, 4'h6, 8'd3, 2'b01);
        tests_run++; if (rvalid_o !== 1'b1) begin tests_failed++; $display("FAIL t6_rvalid_pre: got %b want 1", rvalid_o); end
        #2 reset = 1'b0;
        #1;
        tests_run++; if ({rvalid_o, arready_o} !== 2'b00) begin tests_failed++; $display("FAIL t6_async_abort: got %b want 00", {rvalid_o, arready_o}); end
        @(posedge clk);
        #1 reset = 1'b1;
        rready = 1'b1;
        tests_run++; if (arready_o !== 1'b0) begin tests_failed++; $display("FAIL t6_arready_c0: got %b want 0", arready_o); end
        next_cycle();
        tests_run++; if (arready_o !== 1'b1) begin tests_failed++; $display("FAIL t6_arready_c1: got %b want 1", arready_o); end
        extra = 1'b0;
        repeat (4) begin
            if (rvalid_o !== 1'b0) extra = 1'b1;
            next_cycle();
        end
        rready = 1'b0;
        tests_run++; if (extra !== 1'b0) begin tests_failed++; $display("FAIL t6_no_beats: got %b want 0", extra); end
    endtask

`ifdef CLINT_PRESCALE_EN
    task automatic test_prescale();
        apply_reset();
        repeat (40) next_cycle();
        rready = 1'b1;
        do_ar(BASE, 4'h1, 8'd0, 2'b01);
        tests_run++; if (rdata_o !== 64'd10) begin tests_failed++; $display("FAIL t7_prescale: got %h want %h", rdata_o, 64'd10); end
        next_cycle();
        rready = 1'b0;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mtime_read();
        test_timer_irq();
        test_wstrb();
        test_burst_stall();
        test_errors();
        test_write_burst();
        test_reset_midburst();
`ifdef CLINT_PRESCALE_EN
        test_prescale();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
